// File: rtl/conv_out_ctrl.sv
// Credit-based issue/drain controller between a non-stalling MAC pipeline and the output FIFO.
// Optional credit-stall performance counter enabled by defining OUT_CTRL_PERF_EN.
module conv_out_ctrl #(
    parameter  int DEPTH    = 19,
    parameter  int PIPE_LAT = 4,
    parameter  int CNTW     = 16,
    localparam int LOGDEPTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNTW-1:0]     num_outputs,
    input  logic                in_valid,
    input  logic [LOGDEPTH:0]   fifo_capacity,
    input  logic                fifo_wr_ready,
    input  logic                out_fire,
    output logic                compute_en,
    output logic                fifo_wr_valid,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNTW-1:0]     stall_cycles
);

    localparam int IW   = $clog2(PIPE_LAT + 1);
    localparam int CMPW = (IW > LOGDEPTH + 1) ? IW : LOGDEPTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [PIPE_LAT-1:0]   vld;
    logic [PIPE_LAT-1:0]   vld_next;
    logic [CNTW-1:0]       n_total;
    logic [CNTW-1:0]       issued_cnt;
    logic [CNTW-1:0]       wr_cnt;
    logic [CNTW-1:0]       drained_cnt;
    logic [CNTW-1:0]       drained_next;
    logic [CMPW-1:0]       inflight;
    logic [CMPW-1:0]       cap_ext;

    // Results still inside the MAC pipeline each hold a FIFO slot in reserve.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + CMPW'(vld[i]);
        end
    end

    assign cap_ext       = CMPW'(fifo_capacity);
    assign fifo_wr_valid = vld[PIPE_LAT-1];
    assign compute_en    = (state == RUN) && in_valid && (issued_cnt < n_total) && (inflight < cap_ext);
    assign drained_next  = drained_cnt + CNTW'(out_fire);
    assign out_last      = busy && (drained_cnt == n_total - CNTW'(1)) && (wr_cnt > drained_cnt);

    always_comb begin
        vld_next    = vld << 1;
        vld_next[0] = compute_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            vld         <= '0;
            n_total     <= '0;
            issued_cnt  <= '0;
            wr_cnt      <= '0;
            drained_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            vld        <= vld_next;
            issued_cnt <= issued_cnt + CNTW'(compute_en);
            wr_cnt     <= wr_cnt + CNTW'(fifo_wr_valid);
            done       <= 1'b0;
            if (busy) begin
                drained_cnt <= drained_next;
            end
            // A refused write is dropped but still counted, so the frame cannot finish silently.
            if (fifo_wr_valid && !fifo_wr_ready) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        n_total     <= num_outputs;
                        issued_cnt  <= '0;
                        wr_cnt      <= '0;
                        drained_cnt <= '0;
                        busy        <= 1'b1;
                        if (num_outputs == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued_cnt + CNTW'(compute_en) == n_total) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained_next == n_total) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OUT_CTRL_PERF_EN
    logic [CNTW-1:0] stall_q;
    logic            stall_event;

    assign stall_event  = (state == RUN) && in_valid && (issued_cnt < n_total) && !compute_en;
    assign stall_cycles = stall_q;

    // Saturating count of cycles where work was ready but no FIFO credit was available.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_q <= '0;
        end else if (stall_event && (stall_q != {CNTW{1'b1}})) begin
            stall_q <= stall_q + CNTW'(1);
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/conv_out_ctrl.md
Name: conv_out_ctrl

Overview:
- Credit-based issue/drain controller for the convolution output path. It sits between the non-stalling MAC pipeline and the output FIFO (DEPTH entries, free-slot `capacity` output).
- Issues one MAC result per cycle only when a FIFO slot is guaranteed at pipeline exit.
- Counts results written and drained for one frame, flags the last output beat, and pulses `done` when the frame has fully left the FIFO.

Parameters:
- DEPTH, 19, output FIFO depth; must match the FIFO instance.
- LOGDEPTH, $clog2(DEPTH), localparam; capacity width is LOGDEPTH+1.
- PIPE_LAT, 4, cycles from `compute_en` to result at FIFO input (>=1).
- CNTW, 16, width of frame output counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle frame start; accepted only in IDLE.
- num_outputs  in  CNTW  results in frame; sampled at accepted start.
- in_valid  in  1  MAC operands available this cycle.
- fifo_capacity  in  LOGDEPTH+1  free FIFO slots (registered in FIFO).
- fifo_wr_ready  in  1  FIFO IN_AXIS_TREADY.
- out_fire  in  1  FIFO OUT_AXIS_TVALID && OUT_AXIS_TREADY.
- compute_en  out  1  issue one operand set into MAC pipeline.
- fifo_wr_valid  out  1  drives FIFO IN_AXIS_TVALID (pipeline exit bit).
- out_last  out  1  current FIFO head is final frame result (TLAST).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  sticky: fifo_wr_valid && !fifo_wr_ready seen.
- stall_cycles  out  CNTW  credit-stall counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; valid shift register, counters and latched count cleared. Reset mid-frame aborts immediately; no `done`.
- FSM states:
  - IDLE: start -> latch N = num_outputs, clear counters. Go to DONE if N==0, else to RUN.
  - RUN: issue phase. Go to DRAIN when issued_cnt reaches N (the cycle after the last issue).
  - DRAIN: no issue. Go to DONE when drained_cnt reaches N.
  - DONE: `done`=1 for exactly this cycle, then IDLE.
- Start outside IDLE is ignored.
- Valid shift register vld[PIPE_LAT-1:0]:
  - Shifts every cycle; vld[0] <= compute_en.
  - fifo_wr_valid = vld[PIPE_LAT-1] (combinational from the register).
  - inflight = popcount(vld).
- Issue rule (combinational): compute_en = (state==RUN) && in_valid && (issued_cnt < N) && (inflight < fifo_capacity).
  - Conservative: FIFO reads only raise capacity; an exiting write lowers capacity and inflight on the same edge.
  - Guarantees no write is refused. A refused write sets `err` (sticky until reset); the result is dropped and wr_cnt still advances.
- Counters: issued_cnt += compute_en; wr_cnt += fifo_wr_valid; drained_cnt += out_fire while busy. All are CNTW bits and never wrap within a frame (N <= 2^CNTW-1).
- out_last = busy && (drained_cnt == N-1) && (wr_cnt > drained_cnt), i.e. the head exists and is the Nth result.
- Latency: first result reaches the FIFO PIPE_LAT cycles after the first compute_en. `done` comes 1 cycle after the cycle of the Nth out_fire.
- Simultaneous last issue and last drain cannot occur (drain lags issue by >= PIPE_LAT+1 cycles).
- fifo_capacity==0 with inflight==0 blocks issue until a read frees a slot.

Optional Feature:
- Macro OUT_CTRL_PERF_EN.
- Defined: stall_cycles counts cycles with state==RUN && in_valid && issued_cnt<N && !compute_en. It saturates at 2^CNTW-1, clears at accepted start and at reset, and holds after the frame.
- Undefined: no counter logic; stall_cycles tied to 0.

Test Plan:
- N=5, in_valid=1, out_fire every cycle (DEPTH=19, PIPE_LAT=4) -> compute_en high 5 consecutive cycles; fifo_wr_valid 5 cycles starting 4 later; out_last on the 5th drain; `done` one cycle after it; err=0.
- N=30, downstream never ready -> exactly 19 compute_en total, issue stalls with inflight+stored=19, err=0. Release ready -> remaining 11 issue; `done` after 30 drains; with OUT_CTRL_PERF_EN, stall_cycles equals the counted blocked cycles.
- N=0 start -> busy for 1 cycle (DONE), `done` pulse, no compute_en, no fifo_wr_valid.
- N=8, reset asserted after 3 issues -> next cycle all outputs 0, IDLE, vld cleared. A new start with N=2 completes normally.
- Force fifo_wr_ready=0 while fifo_wr_valid=1 -> err=1 next cycle and stays 1 until reset.
- Start pulsed during RUN with N=3 (frame N=10) -> ignored; frame completes after exactly 10 drains.
